// File: rtl/radio_ctrl_cmd_master_pkg.sv
// Shared types and field positions for the radio settings-bus command master.
package radio_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_WAIT_RB = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  localparam logic [1:0] RESP_OK      = 2'd0;
  localparam logic [1:0] RESP_TIMEOUT = 2'd1;

  localparam int RB_FLAG_BIT = 63;
  localparam int SEQ_LSB     = 40;
  localparam int ADDR_LSB    = 32;
  localparam int DATA_LSB    = 0;

endpackage

// File: rtl/radio_ctrl_cmd_master_rb_watchdog.sv
// Readback timeout down-counter; built only when RADIO_CTRL_CMD_TIMEOUT_EN is defined.
`ifdef RADIO_CTRL_CMD_TIMEOUT_EN
module rb_watchdog #(
  parameter int unsigned RB_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic run_i,
  output logic expire_o
);

  logic [15:0] cnt_q;

  // Loaded with RB_TIMEOUT-1 so terminal count lands on the last waiting cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= 16'(RB_TIMEOUT - 1);
    end else if (run_i && (cnt_q != 16'd0)) begin
      cnt_q <= cnt_q - 16'd1;
    end
  end

  assign expire_o = run_i && (cnt_q == 16'd0);

endmodule
`endif

// File: rtl/radio_ctrl_cmd_master.sv
// Settings-bus initiator: command stream in, settings write + optional readback, response out.
// Readback timeout is present only when RADIO_CTRL_CMD_TIMEOUT_EN is defined.
//
// state      | meaning
// IDLE       | ready for a command
// WRITE      | set_stb pulse, readback strobe accepted in same cycle
// WAIT_RB    | waiting for rb_stb (or timeout)
// RESP       | response held until resp_tready
module radio_ctrl_cmd_master
  import radio_ctrl_pkg::*;
#(
  parameter int unsigned RB_TIMEOUT = 255,
  parameter bit          ACK_WRITES = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] cmd_tdata,
  input  logic        cmd_tvalid,
  output logic        cmd_tready,
  output logic        set_stb,
  output logic [7:0]  set_addr,
  output logic [31:0] set_data,
  output logic [7:0]  rb_addr,
  input  logic        rb_stb,
  input  logic [63:0] rb_data,
  output logic [63:0] resp_tdata,
  output logic [7:0]  resp_seq,
  output logic [1:0]  resp_status,
  output logic        resp_tvalid,
  input  logic        resp_tready,
  output logic        busy,
  output logic [7:0]  rb_stray_cnt
);

  state_e      state_q;
  logic        flag_q;
  logic [7:0]  seq_q;
  logic        cmd_tready_q;
  logic        set_stb_q;
  logic [7:0]  set_addr_q;
  logic [31:0] set_data_q;
  logic [7:0]  rb_addr_q;
  logic [63:0] resp_tdata_q;
  logic [7:0]  resp_seq_q;
  logic [1:0]  resp_status_q;
  logic        resp_tvalid_q;
  logic [7:0]  stray_q;
  logic [7:0]  stray_d;
  logic        stray_hit;
  logic        rb_expire;
  logic        unused_rsvd;

  assign unused_rsvd = ^cmd_tdata[62:48];

`ifdef RADIO_CTRL_CMD_TIMEOUT_EN
  rb_watchdog #(.RB_TIMEOUT(RB_TIMEOUT)) u_rb_watchdog (
    .clk      (clk),
    .rst_n    (reset),
    .load_i   (state_q == ST_WRITE),
    .run_i    (state_q == ST_WAIT_RB),
    .expire_o (rb_expire)
  );
`else
  logic unused_cfg;
  assign unused_cfg = (RB_TIMEOUT == 0);
  assign rb_expire  = 1'b0;
`endif

  // A strobe is stray whenever no readback is being waited for.
  assign stray_hit = (state_q == ST_IDLE) || (state_q == ST_RESP) ||
                     ((state_q == ST_WRITE) && !flag_q);

  always_comb begin
    stray_d = stray_q;
    if (rb_stb && stray_hit && (stray_q != 8'hFF)) stray_d = stray_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      flag_q        <= 1'b0;
      seq_q         <= '0;
      cmd_tready_q  <= 1'b0;
      set_stb_q     <= 1'b0;
      set_addr_q    <= '0;
      set_data_q    <= '0;
      rb_addr_q     <= '0;
      resp_tdata_q  <= '0;
      resp_seq_q    <= '0;
      resp_status_q <= RESP_OK;
      resp_tvalid_q <= 1'b0;
      stray_q       <= '0;
    end else begin
      set_stb_q <= 1'b0;
      stray_q   <= stray_d;
      case (state_q)
        ST_IDLE: begin
          cmd_tready_q <= 1'b1;
          if (cmd_tvalid && cmd_tready_q) begin
            cmd_tready_q <= 1'b0;
            set_stb_q    <= 1'b1;
            set_addr_q   <= cmd_tdata[ADDR_LSB +: 8];
            set_data_q   <= cmd_tdata[DATA_LSB +: 32];
            seq_q        <= cmd_tdata[SEQ_LSB +: 8];
            flag_q       <= cmd_tdata[RB_FLAG_BIT];
            if (cmd_tdata[RB_FLAG_BIT]) rb_addr_q <= cmd_tdata[ADDR_LSB +: 8];
            state_q      <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          resp_seq_q <= seq_q;
          if (flag_q) begin
            if (rb_stb) begin
              resp_tdata_q  <= rb_data;
              resp_status_q <= RESP_OK;
              resp_tvalid_q <= 1'b1;
              state_q       <= ST_RESP;
            end else begin
              state_q <= ST_WAIT_RB;
            end
          end else if (ACK_WRITES) begin
            resp_tdata_q  <= '0;
            resp_status_q <= RESP_OK;
            resp_tvalid_q <= 1'b1;
            state_q       <= ST_RESP;
          end else begin
            cmd_tready_q <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end
        ST_WAIT_RB: begin
          if (rb_stb) begin
            resp_tdata_q  <= rb_data;
            resp_status_q <= RESP_OK;
            resp_tvalid_q <= 1'b1;
            state_q       <= ST_RESP;
          end else if (rb_expire) begin
            resp_tdata_q  <= '0;
            resp_status_q <= RESP_TIMEOUT;
            resp_tvalid_q <= 1'b1;
            state_q       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_tready) begin
            resp_tvalid_q <= 1'b0;
            cmd_tready_q  <= 1'b1;
            state_q       <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_tready   = cmd_tready_q;
  assign set_stb      = set_stb_q;
  assign set_addr     = set_addr_q;
  assign set_data     = set_data_q;
  assign rb_addr      = rb_addr_q;
  assign resp_tdata   = resp_tdata_q;
  assign resp_seq     = resp_seq_q;
  assign resp_status  = resp_status_q;
  assign resp_tvalid  = resp_tvalid_q;
  assign busy         = (state_q != ST_IDLE);
  assign rb_stray_cnt = stray_q;

endmodule

// File: tb/tb_radio_ctrl_cmd_master.sv
// Scoreboard bench for radio_ctrl_cmd_master: ACK_WRITES=1 instance plus a silent-write instance.
module tb_radio_ctrl_cmd_master;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  seq;
    logic [1:0]  status;
    int          cyc;
  } resp_exp_t;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    int          cyc;
  } stb_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // instance A: ACK_WRITES=1
  logic [63:0] cmd_tdata = '0;
  logic        cmd_tvalid = 1'b0, rb_stb = 1'b0, resp_tready = 1'b1;
  logic [63:0] rb_data = '0;
  logic        cmd_tready, set_stb, resp_tvalid, busy;
  logic [7:0]  set_addr, rb_addr, resp_seq, rb_stray_cnt;
  logic [31:0] set_data;
  logic [63:0] resp_tdata;
  logic [1:0]  resp_status;

  radio_ctrl_cmd_master #(.RB_TIMEOUT(16), .ACK_WRITES(1'b1)) dut_a (
    .clk(clk), .reset(rst_n), .cmd_tdata(cmd_tdata), .cmd_tvalid(cmd_tvalid),
    .cmd_tready(cmd_tready), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .rb_addr(rb_addr), .rb_stb(rb_stb), .rb_data(rb_data), .resp_tdata(resp_tdata),
    .resp_seq(resp_seq), .resp_status(resp_status), .resp_tvalid(resp_tvalid),
    .resp_tready(resp_tready), .busy(busy), .rb_stray_cnt(rb_stray_cnt)
  );

  // instance B: silent writes
  logic [63:0] cmd_tdata_b = '0;
  logic        cmd_tvalid_b = 1'b0, rb_stb_b = 1'b0, resp_tready_b = 1'b1;
  logic [63:0] rb_data_b = '0;
  logic        cmd_tready_b, set_stb_b, resp_tvalid_b, busy_b;
  logic [7:0]  set_addr_b, rb_addr_b, resp_seq_b, rb_stray_cnt_b;
  logic [31:0] set_data_b;
  logic [63:0] resp_tdata_b;
  logic [1:0]  resp_status_b;

  radio_ctrl_cmd_master #(.RB_TIMEOUT(16), .ACK_WRITES(1'b0)) dut_b (
    .clk(clk), .reset(rst_n), .cmd_tdata(cmd_tdata_b), .cmd_tvalid(cmd_tvalid_b),
    .cmd_tready(cmd_tready_b), .set_stb(set_stb_b), .set_addr(set_addr_b), .set_data(set_data_b),
    .rb_addr(rb_addr_b), .rb_stb(rb_stb_b), .rb_data(rb_data_b), .resp_tdata(resp_tdata_b),
    .resp_seq(resp_seq_b), .resp_status(resp_status_b), .resp_tvalid(resp_tvalid_b),
    .resp_tready(resp_tready_b), .busy(busy_b), .rb_stray_cnt(rb_stray_cnt_b)
  );

  resp_exp_t sb_q[$];
  stb_exp_t  stb_q[$];
  int          b_cyc[$];
  logic [7:0]  b_addr[$];
  logic [31:0] b_data[$];
  int          b_resp_seen = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // response monitor
  logic        in_resp = 1'b0;
  logic [63:0] held_data;
  logic [9:0]  held_meta;
  int          start_cyc;
  always @(negedge clk) begin
    if (!rst_n) begin
      in_resp = 1'b0;
    end else if (resp_tvalid) begin
      if (!in_resp) begin
        in_resp   = 1'b1;
        start_cyc = cyc;
        held_data = resp_tdata;
        held_meta = {resp_seq, resp_status};
      end else begin
        chk("resp_stable_data", resp_tdata, held_data);
        chk("resp_stable_meta", {resp_seq, resp_status}, held_meta);
      end
      if (resp_tready) begin
        in_resp = 1'b0;
        chk("resp_expected", sb_q.size() != 0, 1'b1);
        if (sb_q.size() != 0) begin
          resp_exp_t e;
          e = sb_q.pop_front();
          chk("resp_data", resp_tdata, e.data);
          chk("resp_seq", resp_seq, e.seq);
          chk("resp_status", resp_status, e.status);
          chk("resp_cycle", start_cyc, e.cyc);
        end
      end
    end
  end

  // settings strobe monitors
  always @(negedge clk) begin
    if (rst_n && set_stb) begin
      chk("stb_expected", stb_q.size() != 0, 1'b1);
      if (stb_q.size() != 0) begin
        stb_exp_t s;
        s = stb_q.pop_front();
        chk("stb_addr", set_addr, s.addr);
        chk("stb_data", set_data, s.data);
        chk("stb_cycle", cyc, s.cyc);
      end
    end
    if (rst_n && set_stb_b) begin
      b_cyc.push_back(cyc);
      b_addr.push_back(set_addr_b);
      b_data.push_back(set_data_b);
    end
    if (rst_n && resp_tvalid_b) b_resp_seen++;
  end

  task automatic send(input logic [63:0] c, output int n);
    bit got = 1'b0;
    n = 0;
    @(posedge clk); #1;
    cmd_tdata  = c;
    cmd_tvalid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (cmd_tready) begin
        n = cyc;
        got = 1'b1;
        break;
      end
    end
    chk("cmd_accepted", got, 1'b1);
    @(posedge clk); #1;
    cmd_tvalid = 1'b0;
  endtask

  task automatic wait_cycle(input int m);
    for (int k = 0; k < 500 && cyc < m; k++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_rb(input logic [63:0] d);
    rb_data = d;
    rb_stb  = 1'b1;
    @(posedge clk); #1;
    rb_stb  = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && sb_q.size() != 0; k++) @(negedge clk);
    chk("drain", sb_q.size(), 0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"}, {cmd_tready, set_stb, set_addr, set_data, rb_addr, resp_seq,
                       resp_status, resp_tvalid, busy, rb_stray_cnt}, '0);
    chk({nm, "_rdata"}, resp_tdata, '0);
  endtask

  function automatic logic [63:0] mk(input bit f, input logic [14:0] rsvd, input logic [7:0] seq,
                                     input logic [7:0] addr, input logic [31:0] data);
    return {f, rsvd, seq, addr, data};
  endfunction

  initial begin
    int n, r;
    int acc0;
    int idx;
    #3;
    chk_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_reset", cmd_tready, 1'b1);
    chk("busy_idle", busy, 1'b0);

    // plain write with response
    send(mk(1'b0, 15'h0, 8'h11, 8'hA4, 32'h1234_5678), n);
    stb_q.push_back('{8'hA4, 32'h1234_5678, n + 1});
    sb_q.push_back('{64'h0, 8'h11, 2'd0, n + 2});
    drain();

    // readback, responder 3 cycles after set_stb, reserved bits set
    send(mk(1'b1, 15'h5A5A, 8'h22, 8'h10, 32'h0000_00FF), n);
    stb_q.push_back('{8'h10, 32'h0000_00FF, n + 1});
    sb_q.push_back('{64'hCAFE_F00D_0000_0001, 8'h22, 2'd0, n + 5});
    wait_cycle(n + 4);
    pulse_rb(64'hCAFE_F00D_0000_0001);
    drain();
    chk("rb_addr_10", rb_addr, 8'h10);

    // same-cycle responder during WRITE
    send(mk(1'b1, 15'h0, 8'h33, 8'h20, 32'hDEAD_0000), n);
    stb_q.push_back('{8'h20, 32'hDEAD_0000, n + 1});
    sb_q.push_back('{64'h0123_4567_89AB_CDEF, 8'h33, 2'd0, n + 2});
    pulse_rb(64'h0123_4567_89AB_CDEF);
    drain();
    chk("rb_addr_20", rb_addr, 8'h20);

    @(posedge clk); #1;
    pulse_rb(64'hFFFF);
    @(negedge clk);
    chk("stray_cnt_1", rb_stray_cnt, 8'd1);

`ifdef RADIO_CTRL_CMD_TIMEOUT_EN
    send(mk(1'b1, 15'h0, 8'h44, 8'h30, 32'h0), n);
    stb_q.push_back('{8'h30, 32'h0, n + 1});
    sb_q.push_back('{64'h0, 8'h44, 2'd1, n + 18});
    drain();
    @(posedge clk); #1;
    pulse_rb(64'h5555);
    @(negedge clk);
    chk("stray_cnt_2", rb_stray_cnt, 8'd2);

    // strobe on the expiry cycle: OK wins
    send(mk(1'b1, 15'h0, 8'h45, 8'h31, 32'h1), n);
    stb_q.push_back('{8'h31, 32'h1, n + 1});
    sb_q.push_back('{64'h1111_2222_3333_4444, 8'h45, 2'd0, n + 18});
    wait_cycle(n + 17);
    pulse_rb(64'h1111_2222_3333_4444);
    drain();
`endif

    // response backpressure
    @(posedge clk); #1;
    resp_tready = 1'b0;
    send(mk(1'b0, 15'h0, 8'h55, 8'hA8, 32'hCAFE_BABE), n);
    stb_q.push_back('{8'hA8, 32'hCAFE_BABE, n + 1});
    sb_q.push_back('{64'h0, 8'h55, 2'd0, n + 2});
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      chk("bp_cmd_tready_low", cmd_tready, 1'b0);
      if (i >= 1) chk("bp_resp_valid", resp_tvalid, 1'b1);
    end
    @(posedge clk); #1;
    resp_tready = 1'b1;
    r = cyc;
    @(negedge clk);
    chk("bp_ready_at_R", cmd_tready, 1'b0);
    @(negedge clk);
    chk("bp_ready_R_plus1", cmd_tready, 1'b1);
    chk("bp_cycle", cyc, r + 1);
    drain();

    // silent writes back-to-back on instance B
    idx = 0;
    acc0 = 0;
    @(posedge clk); #1;
    cmd_tdata_b  = {32'h0000_0001, 32'h1000_0000};
    cmd_tvalid_b = 1'b1;
    for (int k = 0; k < 50 && idx < 4; k++) begin
      @(negedge clk);
      if (cmd_tready_b) begin
        if (idx == 0) acc0 = cyc;
        idx++;
      end
      @(posedge clk); #1;
      if (idx < 4) cmd_tdata_b = {24'h0, 8'(idx + 1), 32'h1000_0000 + 32'(idx)};
      else cmd_tvalid_b = 1'b0;
    end
    cmd_tvalid_b = 1'b0;
    repeat (6) @(negedge clk);
    chk("b_stb_count", b_cyc.size(), 4);
    for (int i = 0; i < 4 && i < b_cyc.size(); i++) begin
      chk("b_stb_cycle", b_cyc[i], acc0 + 1 + 2 * i);
      chk("b_stb_addr", b_addr[i], 8'(i + 1));
      chk("b_stb_data", b_data[i], 32'h1000_0000 + 32'(i));
    end
    chk("b_no_resp", b_resp_seen, 0);

    // reset while waiting for readback
    send(mk(1'b1, 15'h0, 8'h66, 8'h40, 32'h0000_0040), n);
    stb_q.push_back('{8'h40, 32'h0000_0040, n + 1});
    wait_cycle(n + 4);
    #2 rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_reset_busy", busy, 1'b0);
    send(mk(1'b0, 15'h0, 8'h77, 8'h0B, 32'h00C0_FFEE), n);
    stb_q.push_back('{8'h0B, 32'h00C0_FFEE, n + 1});
    sb_q.push_back('{64'h0, 8'h77, 2'd0, n + 2});
    drain();

    repeat (3) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);
    chk("stb_empty", stb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation ran past its time limit");
    $fatal(1, "global timeout");
  end

endmodule
